// File: rtl/qkv_stream_sequencer.sv
// Streams Q rows and paired K/V rows from single-cycle-latency SRAMs to the score stage,
// using 2-entry output buffers with credit-gated read issue so reads never overrun them.
module qkv_stream_sequencer #(
    parameter int SEQ_LEN = 64,
    parameter int NUM_Q   = 64,
    parameter int VEC_W   = 512,
    localparam int QA_W   = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    localparam int KA_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             q_rd_en,
    output logic [QA_W-1:0]  q_rd_addr,
    input  logic [VEC_W-1:0] q_rd_data,
    output logic             kv_rd_en,
    output logic [KA_W-1:0]  kv_rd_addr,
    input  logic [VEC_W-1:0] k_rd_data,
    input  logic [VEC_W-1:0] v_rd_data,
    output logic             Q_vld_out,
    input  logic             Q_rdy_in,
    output logic [VEC_W-1:0] q_out,
    output logic             K_vld_out,
    input  logic             K_rdy_in,
    output logic [VEC_W-1:0] k_out,
    output logic             V_vld_out,
    input  logic             V_rdy_in,
    output logic [VEC_W-1:0] v_out
);
    localparam int TOTAL_KV = NUM_Q * SEQ_LEN;
    localparam int QC_W     = $clog2(NUM_Q + 1);
    localparam int KC_W     = $clog2(TOTAL_KV + 1);
    localparam logic [QC_W-1:0] NUM_Q_C    = QC_W'(NUM_Q);
    localparam logic [KC_W-1:0] TOTAL_KV_C = KC_W'(TOTAL_KV);
    localparam logic [KA_W-1:0] LAST_KEY   = KA_W'(SEQ_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic              run;

    logic [QC_W-1:0]   q_issued_q, q_pops_q;
    logic              q_inflight_q;
    logic [1:0]        q_occ_q, q_occ_d;
    logic              q_wr_ptr_q, q_rd_ptr_q;
    logic [VEC_W-1:0]  q_mem_q [2];
    logic              q_pop;
    logic [2:0]        q_credit;

    logic [KC_W-1:0]   kv_issued_q, kv_pops_q;
    logic [KA_W-1:0]   kv_key_q;
    logic              kv_inflight_q;
    logic [1:0]        kv_occ_q, kv_occ_d;
    logic              kv_wr_ptr_q, kv_rd_ptr_q;
    logic [VEC_W-1:0]  k_mem_q [2];
    logic [VEC_W-1:0]  v_mem_q [2];
    logic              k_sent_q, v_sent_q;
    logic              k_hs, v_hs, kv_pop;
    logic [2:0]        kv_credit;

    assign run  = (state_q == RUN);
    assign busy = run;
    assign done = done_q;

    assign Q_vld_out = (q_occ_q != 2'd0);
    assign q_out     = q_mem_q[q_rd_ptr_q];
    assign q_pop     = Q_vld_out && Q_rdy_in;
    assign q_occ_d   = q_occ_q + 2'(q_inflight_q) - 2'(q_pop);
    // A same-cycle pop frees its slot immediately, sustaining one read per cycle.
    assign q_credit  = 3'(q_occ_q) + 3'(q_inflight_q) - 3'(q_pop);
    assign q_rd_en   = run && (q_issued_q < NUM_Q_C) && (q_credit < 3'd2);
    assign q_rd_addr = QA_W'(q_issued_q);

    assign K_vld_out  = (kv_occ_q != 2'd0) && !k_sent_q;
    assign V_vld_out  = (kv_occ_q != 2'd0) && !v_sent_q;
    assign k_out      = k_mem_q[kv_rd_ptr_q];
    assign v_out      = v_mem_q[kv_rd_ptr_q];
    assign k_hs       = K_vld_out && K_rdy_in;
    assign v_hs       = V_vld_out && V_rdy_in;
    assign kv_pop     = (kv_occ_q != 2'd0) && (k_sent_q || k_hs) && (v_sent_q || v_hs);
    assign kv_occ_d   = kv_occ_q + 2'(kv_inflight_q) - 2'(kv_pop);
    assign kv_credit  = 3'(kv_occ_q) + 3'(kv_inflight_q) - 3'(kv_pop);
    assign kv_rd_en   = run && (kv_issued_q < TOTAL_KV_C) && (kv_credit < 3'd2);
    assign kv_rd_addr = kv_key_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (done_q) begin
                    state_d = IDLE;
                end else if ((q_pops_q + QC_W'(q_pop) == NUM_Q_C) &&
                             (kv_pops_q + KC_W'(kv_pop) == TOTAL_KV_C)) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Run counters return to zero as the run ends so the next start begins at row 0, key 0.
    always_ff @(posedge clk) begin
        if (rst || done_q) begin
            q_issued_q  <= '0;
            q_pops_q    <= '0;
            kv_issued_q <= '0;
            kv_pops_q   <= '0;
            kv_key_q    <= '0;
        end else begin
            if (q_rd_en) q_issued_q <= q_issued_q + 1'b1;
            if (q_pop)   q_pops_q   <= q_pops_q + 1'b1;
            if (kv_rd_en) begin
                kv_issued_q <= kv_issued_q + 1'b1;
                kv_key_q    <= (kv_key_q == LAST_KEY) ? '0 : kv_key_q + 1'b1;
            end
            if (kv_pop) kv_pops_q <= kv_pops_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_inflight_q <= 1'b0;
            q_occ_q      <= 2'd0;
            q_wr_ptr_q   <= 1'b0;
            q_rd_ptr_q   <= 1'b0;
            q_mem_q      <= '{default: '0};
        end else begin
            q_inflight_q <= q_rd_en;
            q_occ_q      <= q_occ_d;
            if (q_inflight_q) begin
                q_mem_q[q_wr_ptr_q] <= q_rd_data;
                q_wr_ptr_q          <= ~q_wr_ptr_q;
            end
            if (q_pop) q_rd_ptr_q <= ~q_rd_ptr_q;
        end
    end

    // Clearing the in-flight flag on reset is what drops read data returning after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            kv_inflight_q <= 1'b0;
            kv_occ_q      <= 2'd0;
            kv_wr_ptr_q   <= 1'b0;
            kv_rd_ptr_q   <= 1'b0;
            k_mem_q       <= '{default: '0};
            v_mem_q       <= '{default: '0};
            k_sent_q      <= 1'b0;
            v_sent_q      <= 1'b0;
        end else begin
            kv_inflight_q <= kv_rd_en;
            kv_occ_q      <= kv_occ_d;
            if (kv_inflight_q) begin
                k_mem_q[kv_wr_ptr_q] <= k_rd_data;
                v_mem_q[kv_wr_ptr_q] <= v_rd_data;
                kv_wr_ptr_q          <= ~kv_wr_ptr_q;
            end
            if (kv_pop) begin
                kv_rd_ptr_q <= ~kv_rd_ptr_q;
                k_sent_q    <= 1'b0;
                v_sent_q    <= 1'b0;
            end else begin
                if (k_hs) k_sent_q <= 1'b1;
                if (v_hs) v_sent_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qkv_stream_sequencer.sv
// Bench for qkv_stream_sequencer with SEQ_LEN=4, NUM_Q=2 and SRAM row i holding
// Q=0x100+i, K=0x200+i, V=0x300+i.
module tb_qkv_stream_sequencer;
    localparam int SEQ_LEN = 4;
    localparam int NUM_Q   = 2;
    localparam int VEC_W   = 16;

    logic             clk = 1'b0;
    logic             rst, start;
    logic             busy, done;
    logic             q_rd_en, kv_rd_en;
    logic [0:0]       q_rd_addr;
    logic [1:0]       kv_rd_addr;
    logic [VEC_W-1:0] q_rd_data, k_rd_data, v_rd_data;
    logic             Q_vld_out, K_vld_out, V_vld_out;
    logic             Q_rdy_in, K_rdy_in, V_rdy_in;
    logic [VEC_W-1:0] q_out, k_out, v_out;

    always #5 clk = ~clk;

    qkv_stream_sequencer #(.SEQ_LEN(SEQ_LEN), .NUM_Q(NUM_Q), .VEC_W(VEC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
        .kv_rd_en(kv_rd_en), .kv_rd_addr(kv_rd_addr),
        .k_rd_data(k_rd_data), .v_rd_data(v_rd_data),
        .Q_vld_out(Q_vld_out), .Q_rdy_in(Q_rdy_in), .q_out(q_out),
        .K_vld_out(K_vld_out), .K_rdy_in(K_rdy_in), .k_out(k_out),
        .V_vld_out(V_vld_out), .V_rdy_in(V_rdy_in), .v_out(v_out)
    );

    // SRAM models: registered read, independent of the sequencer reset
    always_ff @(posedge clk) begin
        if (q_rd_en) q_rd_data <= 16'h100 + 16'(q_rd_addr);
        if (kv_rd_en) begin
            k_rd_data <= 16'h200 + 16'(kv_rd_addr);
            v_rd_data <= 16'h300 + 16'(kv_rd_addr);
        end
    end

    typedef struct packed {
        logic        start, qr, kr, vr;
        logic        busy, done, qen, kven, qv;
        logic [15:0] q;
        logic        kv;
        logic [15:0] k;
        logic        vv;
        logic [15:0] v;
    } vec_t;

    vec_t tbl [13];

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] qq[$], kq[$], vq[$];
    int          qrd, kvrd, done_cnt;
    logic        q_stall, k_stall, v_stall;
    logic [15:0] q_prev, k_prev, v_prev;

    function automatic vec_t mk(logic s, logic b, logic d, logic qe, logic ke,
                                logic qv, logic [15:0] q, logic kv, logic [15:0] k,
                                logic vv, logic [15:0] v);
        vec_t r;
        r.start = s; r.qr = 1'b1; r.kr = 1'b1; r.vr = 1'b1;
        r.busy = b; r.done = d; r.qen = qe; r.kven = ke;
        r.qv = qv; r.q = q; r.kv = kv; r.k = k; r.vv = vv; r.v = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        qq.delete(); kq.delete(); vq.delete();
        qrd = 0; kvrd = 0; done_cnt = 0;
        q_stall = 1'b0; k_stall = 1'b0; v_stall = 1'b0;
    endtask

    // Per-cycle observer: addresses, hold-while-stalled, handshake capture, credit bound
    task automatic monitor();
        int pairs;
        if (q_rd_en) begin
            chk("q_rd_addr", 64'(q_rd_addr), 64'(qrd));
            qrd++;
        end
        if (kv_rd_en) begin
            chk("kv_rd_addr", 64'(kv_rd_addr), 64'(kvrd % SEQ_LEN));
            kvrd++;
        end
        if (q_stall) chk("q_hold", 64'({Q_vld_out, q_out}), 64'({1'b1, q_prev}));
        if (k_stall) chk("k_hold", 64'({K_vld_out, k_out}), 64'({1'b1, k_prev}));
        if (v_stall) chk("v_hold", 64'({V_vld_out, v_out}), 64'({1'b1, v_prev}));
        if (Q_vld_out && Q_rdy_in) qq.push_back(q_out);
        if (K_vld_out && K_rdy_in) kq.push_back(k_out);
        if (V_vld_out && V_rdy_in) vq.push_back(v_out);
        pairs = (kq.size() < vq.size()) ? kq.size() : vq.size();
        if (kv_rd_en) chk("kv_outstanding_le2", 64'(kvrd - pairs <= 2), 64'(1));
        if (done) done_cnt++;
        q_stall = Q_vld_out && !Q_rdy_in; q_prev = q_out;
        k_stall = K_vld_out && !K_rdy_in; k_prev = k_out;
        v_stall = V_vld_out && !V_rdy_in; v_prev = v_out;
    endtask

    task automatic chk_seqs(input string tag, input int nq, input int nkv);
        chk({tag, "_q_count"}, 64'(qq.size()), 64'(nq));
        chk({tag, "_k_count"}, 64'(kq.size()), 64'(nkv));
        chk({tag, "_v_count"}, 64'(vq.size()), 64'(nkv));
        for (int i = 0; i < nq && i < qq.size(); i++)
            chk($sformatf("%s_q%0d", tag, i), 64'(qq[i]), 64'(16'h100 + i));
        for (int i = 0; i < nkv && i < kq.size(); i++)
            chk($sformatf("%s_k%0d", tag, i), 64'(kq[i]), 64'(16'h200 + i % SEQ_LEN));
        for (int i = 0; i < nkv && i < vq.size(); i++)
            chk($sformatf("%s_v%0d", tag, i), 64'(vq[i]), 64'(16'h300 + i % SEQ_LEN));
    endtask

    task automatic run_table(input string tag);
        vec_t e;
        logic [63:0] act, exp;
        clr_mon();
        for (int r = 0; r < 13; r++) begin
            e = tbl[r];
            start = e.start; Q_rdy_in = e.qr; K_rdy_in = e.kr; V_rdy_in = e.vr;
            @(negedge clk);
            monitor();
            act = 64'({busy, done, q_rd_en, kv_rd_en, Q_vld_out, e.qv ? q_out : 16'h0,
                       K_vld_out, e.kv ? k_out : 16'h0, V_vld_out, e.vv ? v_out : 16'h0});
            exp = 64'({e.busy, e.done, e.qen, e.kven, e.qv, e.q, e.kv, e.k, e.vv, e.v});
            chk($sformatf("%s_cyc%0d", tag, r), act, exp);
            tick();
        end
        start = 1'b0;
        chk_seqs(tag, NUM_Q, NUM_Q * SEQ_LEN);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
    endtask

    // mode 1: K/V stall 4-8; 2: K stall 4-6; 3: Q held until 4 K pops; 4: start pulses in RUN
    task automatic run_mode(input int mode, input int exp_done);
        int done_cyc;
        bit fin;
        done_cyc = -1;
        fin = 1'b0;
        clr_mon();
        for (int c = 0; c < 80 && !fin; c++) begin
            start    = (c == 0) || (mode == 4 && (c == 5 || c == 11));
            Q_rdy_in = (mode == 3) ? (qq.size() == 0 || kq.size() >= 4) : 1'b1;
            K_rdy_in = (mode == 1) ? !(c >= 4 && c <= 8) : (mode == 2) ? !(c >= 4 && c <= 6) : 1'b1;
            V_rdy_in = (mode == 1) ? !(c >= 4 && c <= 8) : 1'b1;
            @(negedge clk);
            monitor();
            if (mode == 2 && c == 5)
                chk("kstall_v_waits", 64'({K_vld_out, V_vld_out, k_out}), 64'({2'b10, 16'h201}));
            if (mode == 3 && c == 5)
                chk("qheld_second_q", 64'({Q_vld_out, Q_rdy_in, q_out}), 64'({2'b10, 16'h101}));
            if (done === 1'b1 && done_cyc < 0) begin
                done_cyc = c;
            end else if (done_cyc >= 0 && c == done_cyc + 1) begin
                chk($sformatf("mode%0d_busy_after_done", mode), 64'(busy), 64'(0));
                fin = 1'b1;
            end
            tick();
        end
        start = 1'b0; Q_rdy_in = 1'b1; K_rdy_in = 1'b1; V_rdy_in = 1'b1;
        chk($sformatf("mode%0d_done_cycle", mode), 64'(done_cyc), 64'(exp_done));
        chk_seqs($sformatf("mode%0d", mode), NUM_Q, NUM_Q * SEQ_LEN);
        chk($sformatf("mode%0d_done_pulses", mode), 64'(done_cnt), 64'(1));
        chk($sformatf("mode%0d_q_reads", mode), 64'(qrd), 64'(NUM_Q));
        chk($sformatf("mode%0d_kv_reads", mode), 64'(kvrd), 64'(NUM_Q * SEQ_LEN));
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 16'h0,   0, 16'h0,   0, 16'h0);
        tbl[1]  = mk(0, 1, 0, 1, 1, 0, 16'h0,   0, 16'h0,   0, 16'h0);
        tbl[2]  = mk(0, 1, 0, 1, 1, 0, 16'h0,   0, 16'h0,   0, 16'h0);
        tbl[3]  = mk(0, 1, 0, 0, 1, 1, 16'h100, 1, 16'h200, 1, 16'h300);
        tbl[4]  = mk(0, 1, 0, 0, 1, 1, 16'h101, 1, 16'h201, 1, 16'h301);
        tbl[5]  = mk(0, 1, 0, 0, 1, 0, 16'h0,   1, 16'h202, 1, 16'h302);
        tbl[6]  = mk(0, 1, 0, 0, 1, 0, 16'h0,   1, 16'h203, 1, 16'h303);
        tbl[7]  = mk(0, 1, 0, 0, 1, 0, 16'h0,   1, 16'h200, 1, 16'h300);
        tbl[8]  = mk(0, 1, 0, 0, 1, 0, 16'h0,   1, 16'h201, 1, 16'h301);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 16'h0,   1, 16'h202, 1, 16'h302);
        tbl[10] = mk(0, 1, 0, 0, 0, 0, 16'h0,   1, 16'h203, 1, 16'h303);
        tbl[11] = mk(0, 1, 1, 0, 0, 0, 16'h0,   0, 16'h0,   0, 16'h0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 16'h0,   0, 16'h0,   0, 16'h0);

        rst = 1'b1; start = 1'b0;
        Q_rdy_in = 1'b1; K_rdy_in = 1'b1; V_rdy_in = 1'b1;
        clr_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({busy, done, q_rd_en, kv_rd_en, Q_vld_out, K_vld_out, V_vld_out}), 64'(0));
        chk("reset_addr", 64'({q_rd_addr, kv_rd_addr}), 64'(0));
        chk("reset_data", 64'({q_out, k_out, v_out}), 64'(0));
        tick();
        rst = 1'b0;

        run_table("nominal");
        run_mode(1, 16);
        run_mode(2, 14);
        run_mode(3, 11);
        run_mode(4, 11);
        run_mode(0, 11);

        // Reset during cycle 5: third pair pops and a K/V read is issued that returns after reset
        clr_mon();
        for (int c = 0; c < 5; c++) begin
            start = (c == 0);
            @(negedge clk);
            monitor();
            tick();
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        monitor();
        chk("rst_read_in_flight", 64'(kv_rd_en), 64'(1));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl_cleared", 64'({busy, done, q_rd_en, kv_rd_en, Q_vld_out, K_vld_out, V_vld_out}), 64'(0));
        tick();
        @(negedge clk);
        chk("rst_stale_dropped", 64'({Q_vld_out, K_vld_out, V_vld_out, busy}), 64'(0));
        chk("rst_bufs_clear", 64'({q_out, k_out, v_out}), 64'(0));
        tick();
        chk("rst_pairs_before", 64'(kq.size()), 64'(3));
        run_table("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
